iot_event_arbiter: RTL and testbench
====================================

IOT_EVENT_ARBITER -- requirements
Module: iot_event_arbiter

Interface
REQ-001 Parameter SHALL be: N_DEV, 4, number of device requesters (2..8).
REQ-002 Port SHALL be: clk  input  1  single clock; all logic rising-edge.
REQ-003 Port SHALL be: rst  input  1  synchronous, active-low reset.
REQ-004 Port SHALL be: dev_req  input  N_DEV  per-device event request, held until ack/reject.
REQ-005 Port SHALL be: dev_on_off  input  N_DEV  requested device state (1=on, 0=off), stable while dev_req high.
REQ-006 Port SHALL be: count_in  input  8  current count from the active-device monitor.
REQ-007 Port SHALL be: dev_ack  output  N_DEV  one-cycle accept pulse, one-hot.
REQ-008 Port SHALL be: dev_reject  output  N_DEV  one-cycle reject pulse, one-hot.
REQ-009 Port SHALL be: change  output  1  monitor update strobe.
REQ-010 Port SHALL be: on_off  output  1  monitor direction (1=increment, 0=decrement).
REQ-011 Port SHALL be: active_mask  output  N_DEV  registered on/off state per device.
REQ-012 Port SHALL be: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states IDLE, ISSUE and SETTLE, with transitions IDLE->ISSUE when any dev_req is high, ISSUE->SETTLE unconditionally, and SETTLE->IDLE unconditionally.
REQ-015 In IDLE, the winner SHALL be the first index with dev_req high, scanning from rr_ptr upward and wrapping modulo N_DEV.
REQ-016 On leaving IDLE, rr_ptr SHALL be set to (winner+1) mod N_DEV, for both accepted and rejected winners.
REQ-017 The winner SHALL be rejected if dev_on_off[w]==active_mask[w] (redundant), if dev_on_off[w]=1 and count_in==255 (saturation), or if dev_on_off[w]=0 and count_in==0 (underflow).
REQ-018 An accepted winner SHALL produce change=1, on_off=dev_on_off[w], dev_ack[w]=1 and active_mask[w]<=dev_on_off[w], all visible in the ISSUE cycle.
REQ-019 A rejected winner SHALL produce dev_reject[w]=1, change=0 and active_mask unchanged in the ISSUE cycle.
REQ-020 change, dev_ack and dev_reject SHALL be high only during ISSUE, for exactly one cycle per event.
REQ-021 Latency SHALL be: a request sampled in IDLE at edge k is acked or rejected in the cycle after edge k.
REQ-022 Throughput SHALL be at most one event per 3 cycles.
REQ-023 dev_req changes during ISSUE/SETTLE SHALL be ignored; arbitration samples only in IDLE.
REQ-024 A requester SHALL deassert dev_req in the cycle after its ack/reject.
REQ-025 A dev_req still high on return to IDLE SHALL be treated as a new request.
REQ-026 Simultaneous requests SHALL be served one per grant slot in round-robin order, and no requester SHALL wait more than N_DEV slots.
REQ-027 on_off SHALL hold its last value when change=0.
REQ-028 The block SHALL never issue a monitor change for a redundant or out-of-range event.

Reset
REQ-029 While rst=0 at a rising edge, state SHALL become IDLE, rr_ptr=0, active_mask=0, and change, on_off, dev_ack, dev_reject and busy SHALL all be 0.
REQ-030 Reset asserted during ISSUE or SETTLE SHALL abort the event: outputs clear at that edge and no further pulse is issued.
REQ-031 The first arbitration SHALL occur at the first edge with rst=1.

Verification
REQ-032 Reset check: rst=0 for 5 cycles with dev_req=4'b1111 -> all outputs 0, busy=0, no ack.
REQ-033 Single device on: dev_req=4'b0001, dev_on_off=1, count_in=0 -> dev_ack=4'b0001, change=1, on_off=1 for one cycle, active_mask=4'b0001, busy high for 2 cycles.
REQ-034 Round-robin: dev_req=4'b1111 held (redundancy aside) from rr_ptr=0 -> grants in order 0,1,2,3,0; consecutive grants 3 cycles apart.
REQ-035 Rejections: device 2 off while already off -> dev_reject=4'b0100, change stays 0; device on with count_in=255 -> reject; device off with count_in=0 -> reject.
REQ-036 Reset mid-operation: rst=0 in the ISSUE cycle -> change, dev_ack=0 at the next edge, active_mask=0, FSM IDLE.
REQ-037 Scoreboard: random req/on_off for 500 cycles with a modelled counter -> modelled count equals popcount(active_mask), every change matches exactly one ack, and no ack/reject pulses coincide.

Source files
------------

// File: rtl/iot_event_arbiter_if.sv
// Request/grant bundle between device requesters and the event arbiter.
// The master side is the requester/monitor pool; the slave side is the arbiter.
interface iot_event_arbiter_if #(
  parameter int N_DEV = 4
);
  logic [N_DEV-1:0] dev_req;
  logic [N_DEV-1:0] dev_on_off;
  logic [7:0]       count_in;
  logic [N_DEV-1:0] dev_ack;
  logic [N_DEV-1:0] dev_reject;
  logic             change;
  logic             on_off;
  logic [N_DEV-1:0] active_mask;
  logic             busy;

  modport master (
    output dev_req, dev_on_off, count_in,
    input  dev_ack, dev_reject, change, on_off, active_mask, busy
  );

  modport slave (
    input  dev_req, dev_on_off, count_in,
    output dev_ack, dev_reject, change, on_off, active_mask, busy
  );
endinterface

// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter that serialises device on/off events into monitor
// increment/decrement strobes, rejecting redundant or out-of-range events.
module iot_event_arbiter #(
  parameter int N_DEV = 4
) (
  input  logic               clk,
  input  logic               rst,
  iot_event_arbiter_if.slave bus
);
  localparam int PW = (N_DEV > 2) ? $clog2(N_DEV) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [N_DEV-1:0] mask_q, mask_d;
  logic [N_DEV-1:0] ack_q, ack_d;
  logic [N_DEV-1:0] rej_q, rej_d;
  logic             chg_q, chg_d;
  logic             oo_q, oo_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    cand;

  // First requester at or after rr_q, wrapping modulo N_DEV.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_DEV; i++) begin
      cand = PW'((int'(rr_q) + i) % N_DEV);
      if (!found && bus.dev_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  logic want;
  logic reject;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    mask_d  = mask_q;
    ack_d   = '0;
    rej_d   = '0;
    chg_d   = 1'b0;
    oo_d    = oo_q;
    want    = bus.dev_on_off[win];
    reject  = (want == mask_q[win]) ||
              (want && (bus.count_in == 8'hFF)) ||
              (!want && (bus.count_in == 8'h00));
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          rr_d    = PW'((int'(win) + 1) % N_DEV);
          if (reject) begin
            rej_d[win] = 1'b1;
          end else begin
            ack_d[win]  = 1'b1;
            chg_d       = 1'b1;
            oo_d        = want;
            mask_d[win] = want;
          end
        end
      end
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      mask_q  <= '0;
      ack_q   <= '0;
      rej_q   <= '0;
      chg_q   <= 1'b0;
      oo_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      chg_q   <= chg_d;
      oo_q    <= oo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dev_ack     = ack_q;
  assign bus.dev_reject  = rej_q;
  assign bus.change      = chg_q;
  assign bus.on_off      = oo_q;
  assign bus.active_mask = mask_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_iot_event_arbiter.sv
// Scoreboard bench for iot_event_arbiter: directed events push expectations,
// a negedge monitor pops them on every ack/reject pulse.
module tb_iot_event_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  iot_event_arbiter_if #(.N_DEV(N)) bus();
  iot_event_arbiter #(.N_DEV(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0] ack;
    logic [3:0] rej;
    logic [3:0] mask;
    logic       chg;
    logic       oo;
    int         gap;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   npulse   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  bit   sb_on    = 1'b0;
  bit   rnd_on   = 1'b0;
  logic [7:0] cnt = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Modelled active-device counter fed back as count_in in the random phase.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) cnt <= 8'd0;
    else if (rnd_on && bus.change) cnt <= bus.on_off ? cnt + 8'd1 : cnt - 8'd1;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ack_rej_overlap", 32'(bus.dev_ack & bus.dev_reject), 32'd0);
      chk("pulse_onehot", 32'(($countones(bus.dev_ack) + $countones(bus.dev_reject)) <= 1), 32'd1);
      chk("change_vs_ack", 32'(bus.change), 32'(|bus.dev_ack));
      if (rnd_on && rst && !bus.change)
        chk("popcount", 32'(cnt), 32'($countones(bus.active_mask)));
      if ((bus.dev_ack | bus.dev_reject) != 4'd0) begin
        npulse++;
        if (sb_on) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: ack=%b rej=%b with empty queue", bus.dev_ack, bus.dev_reject);
          end else begin
            mon_e = q.pop_front();
            chk("sb_ack", 32'(bus.dev_ack), 32'(mon_e.ack));
            chk("sb_rej", 32'(bus.dev_reject), 32'(mon_e.rej));
            chk("sb_change", 32'(bus.change), 32'(mon_e.chg));
            chk("sb_on_off", 32'(bus.on_off), 32'(mon_e.oo));
            chk("sb_mask", 32'(bus.active_mask), 32'(mon_e.mask));
            if (mon_e.gap != 0) chk("sb_gap", 32'(cyc - last_cyc), 32'(mon_e.gap));
          end
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic push(input logic [3:0] ack, input logic [3:0] rej, input logic chg,
                      input logic oo, input logic [3:0] mask, input int gap);
    exp_t e;
    e.ack = ack; e.rej = rej; e.chg = chg; e.oo = oo; e.mask = mask; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (npulse < n && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    if (npulse < n) begin
      checks++;
      failures++;
      $display("FAIL timeout: pulses=%0d expected %0d", npulse, n);
    end
  endtask

  // Drive one request, wait for its pulse, release, and return in IDLE.
  task automatic do_event(input logic [3:0] req, input logic [3:0] oo, input logic [7:0] c);
    int t;
    t = npulse + 1;
    bus.dev_req    = req;
    bus.dev_on_off = oo;
    bus.count_in   = c;
    wait_pulses(t);
    bus.dev_req = '0;
    @(negedge clk); @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.dev_req = '0;
    repeat (2) begin @(negedge clk); #1; end
    rst = 1'b1;
  endtask

  initial begin
    int c0;
    int t;
    int rp0;
    bus.dev_req    = 4'b1111;
    bus.dev_on_off = 4'b1111;
    bus.count_in   = 8'd0;

    // Reset held with all requests asserted
    repeat (5) begin
      @(negedge clk); #1;
      chk("rst_ack", 32'(bus.dev_ack), 32'd0);
      chk("rst_rej", 32'(bus.dev_reject), 32'd0);
      chk("rst_change", 32'(bus.change), 32'd0);
      chk("rst_on_off", 32'(bus.on_off), 32'd0);
      chk("rst_mask", 32'(bus.active_mask), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
    end

    // Single device on, arbitrated at the first edge out of reset
    sb_on = 1'b1;
    push(4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 0);
    rst = 1'b1;
    bus.dev_req    = 4'b0001;
    bus.dev_on_off = 4'b0001;
    bus.count_in   = 8'd0;
    c0 = cyc;
    wait_pulses(1);
    chk("first_latency", 32'(last_cyc), 32'(c0 + 1));
    chk("busy_issue", 32'(bus.busy), 32'd1);
    bus.dev_req = '0;
    @(negedge clk); #1;
    chk("busy_settle", 32'(bus.busy), 32'd1);
    chk("ack_one_cycle", 32'(bus.dev_ack), 32'd0);
    chk("change_one_cycle", 32'(bus.change), 32'd0);
    chk("on_off_hold", 32'(bus.on_off), 32'd1);
    @(negedge clk); #1;
    chk("busy_idle", 32'(bus.busy), 32'd0);

    // Rejections and an accepted turn-off (mask=0001, rr=1)
    push(4'b0000, 4'b0100, 1'b0, 1'b1, 4'b0001, 0);   // dev2 off while off
    do_event(4'b0100, 4'b0000, 8'd5);
    push(4'b0000, 4'b0010, 1'b0, 1'b1, 4'b0001, 0);   // dev1 on at 255
    do_event(4'b0010, 4'b0010, 8'd255);
    push(4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0001, 0);   // dev0 off at 0
    do_event(4'b0001, 4'b0000, 8'd0);
    push(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 0);   // dev0 off, accepted
    do_event(4'b0001, 4'b0000, 8'd1);
    push(4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 0);   // dev3 on at 255
    do_event(4'b1000, 4'b1000, 8'd255);

    // Round robin with all requests held from rr=0
    do_reset();
    push(4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 0);
    push(4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0011, 3);
    push(4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0111, 3);
    push(4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1111, 3);
    push(4'b0000, 4'b0001, 1'b0, 1'b1, 4'b1111, 3);
    t = npulse + 5;
    bus.dev_req    = 4'b1111;
    bus.dev_on_off = 4'b1111;
    bus.count_in   = 8'd10;
    wait_pulses(t);
    bus.dev_req = '0;
    @(negedge clk); @(negedge clk); #1;

    // Reset during ISSUE (rr=1, mask=1111)
    push(4'b0010, 4'b0000, 1'b1, 1'b0, 4'b1101, 0);
    t = npulse + 1;
    bus.dev_req    = 4'b0010;
    bus.dev_on_off = 4'b0000;
    bus.count_in   = 8'd4;
    wait_pulses(t);
    rst = 1'b0;
    bus.dev_req = '0;
    @(negedge clk); #1;
    chk("midrst_ack", 32'(bus.dev_ack), 32'd0);
    chk("midrst_change", 32'(bus.change), 32'd0);
    chk("midrst_mask", 32'(bus.active_mask), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_quiet", 32'(bus.busy), 32'd0);
    push(4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 0);   // rr back at 0 -> dev1 beats dev3
    do_event(4'b1010, 4'b1010, 8'd3);

    // Random traffic with modelled counter feedback
    sb_on  = 1'b0;
    rnd_on = 1'b1;
    do_reset();
    rp0 = npulse;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (bus.dev_req[i] && (bus.dev_ack[i] || bus.dev_reject[i])) begin
          bus.dev_req[i] = 1'b0;
        end else if (!bus.dev_req[i] && ($urandom_range(3) == 0)) begin
          bus.dev_on_off[i] = 1'($urandom_range(1));
          bus.dev_req[i]    = 1'b1;
        end
      end
      bus.count_in = cnt;
    end
    bus.dev_req = '0;
    repeat (6) begin @(negedge clk); #1; end
    chk("rnd_activity", 32'(npulse > rp0 + 20), 32'd1);
    chk("rnd_final_count", 32'(cnt), 32'($countones(bus.active_mask)));
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
